test_sig_sweep_ctrl: RTL and testbench

TEST_SIG_SWEEP_CTRL -- requirements
Module: test_sig_sweep_ctrl

---
 rtl/test_sig_sweep_ctrl.sv | 176 +++++++++++++++++
 tb/tb_test_sig_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/test_sig_sweep_ctrl.sv
// Frequency-sweep controller for a phase-accumulator tone generator.
// Steps the phase increment through a programmed set of tones, holding each tone for a fixed number of cycles.
module test_sig_sweep_ctrl #(
  parameter int PHASE_W     = 20,
  parameter int STEP_W      = 16,
  parameter int DWELL_W     = 24,
  parameter int RESYNC_EACH = 1
) (
  input  logic               m_axis_aclk,
  input  logic               m_axis_areset,
  input  logic [PHASE_W-1:0] cfg_pinc_start,
  input  logic [PHASE_W-1:0] cfg_pinc_step,
  input  logic [PHASE_W-1:0] cfg_poff,
  input  logic [STEP_W-1:0]  cfg_num_tones,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  output logic [PHASE_W-1:0] pinc,
  output logic [PHASE_W-1:0] poff,
  output logic               resync,
  output logic               valid_in,
  output logic               busy,
  output logic               done,
  output logic [STEP_W-1:0]  tone_idx
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_DWELL  = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [STEP_W-1:0]  TONE_ONE  = STEP_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  logic [2:0]         state_q,      state_d;
  logic [PHASE_W-1:0] pinc_start_q, pinc_start_d;
  logic [PHASE_W-1:0] pinc_step_q,  pinc_step_d;
  logic [PHASE_W-1:0] poff_cfg_q,   poff_cfg_d;
  logic [STEP_W-1:0]  num_tones_q,  num_tones_d;
  logic [DWELL_W-1:0] reload_q,     reload_d;
  logic [DWELL_W-1:0] cnt_q,        cnt_d;
  logic [PHASE_W-1:0] pinc_q,       pinc_d;
  logic [PHASE_W-1:0] poff_q,       poff_d;
  logic [STEP_W-1:0]  tone_idx_q,   tone_idx_d;
  logic               resync_q,     resync_d;
  logic               valid_q,      valid_d;
  logic               busy_q,       busy_d;
  logic               done_q,       done_d;
  logic               last_tone;

  assign last_tone = (tone_idx_q == (num_tones_q - TONE_ONE));

  always_comb begin
    // NOTE: every *_d gets a default before the case so no path leaves a signal unassigned (no latches).
    state_d      = state_q;
    pinc_start_d = pinc_start_q;
    pinc_step_d  = pinc_step_q;
    poff_cfg_d   = poff_cfg_q;
    num_tones_d  = num_tones_q;
    reload_d     = reload_q;
    cnt_d        = cnt_q;
    pinc_d       = pinc_q;
    poff_d       = poff_q;
    tone_idx_d   = tone_idx_q;
    resync_d     = 1'b0;
    valid_d      = valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pinc_start_d = cfg_pinc_start;
          pinc_step_d  = cfg_pinc_step;
          poff_cfg_d   = cfg_poff;
          num_tones_d  = cfg_num_tones;
          // A dwell of zero is treated as one cycle per tone.
          reload_d     = (cfg_dwell == '0) ? '0 : (cfg_dwell - DWELL_ONE);
          state_d      = S_LOAD;
        end
      end

      S_LOAD: begin
        if (abort || (num_tones_q == '0)) begin
          state_d = S_FINISH;
        end else begin
          pinc_d     = pinc_start_q;
          poff_d     = poff_cfg_q;
          tone_idx_d = '0;
          cnt_d      = reload_q;
          valid_d    = 1'b1;
          resync_d   = 1'b1;
          state_d    = S_DWELL;
        end
      end

      S_DWELL, S_STEP: begin
        // The edge leaving the last dwell cycle already presents the next tone, so STEP is its first cycle.
        if (abort) begin
          state_d = S_FINISH;
        end else if (!pause) begin
          if (cnt_q == '0) begin
            if (last_tone) begin
              state_d = S_FINISH;
            end else begin
              pinc_d     = pinc_q + pinc_step_q;
              tone_idx_d = tone_idx_q + TONE_ONE;
              cnt_d      = reload_q;
              resync_d   = (RESYNC_EACH != 0);
              state_d    = S_STEP;
            end
          end else begin
            cnt_d   = cnt_q - DWELL_ONE;
            state_d = S_DWELL;
          end
        end
      end

      S_FINISH: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FINISH) begin
      valid_d = 1'b0;
      done_d  = 1'b1;
    end

    busy_d = (state_d == S_LOAD) || (state_d == S_DWELL) || (state_d == S_STEP);
  end

  always_ff @(posedge m_axis_aclk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (m_axis_areset) begin
      state_q      <= S_IDLE;
      pinc_start_q <= '0;
      pinc_step_q  <= '0;
      poff_cfg_q   <= '0;
      num_tones_q  <= '0;
      reload_q     <= '0;
      cnt_q        <= '0;
      pinc_q       <= '0;
      poff_q       <= '0;
      tone_idx_q   <= '0;
      resync_q     <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pinc_start_q <= pinc_start_d;
      pinc_step_q  <= pinc_step_d;
      poff_cfg_q   <= poff_cfg_d;
      num_tones_q  <= num_tones_d;
      reload_q     <= reload_d;
      cnt_q        <= cnt_d;
      pinc_q       <= pinc_d;
      poff_q       <= poff_d;
      tone_idx_q   <= tone_idx_d;
      resync_q     <= resync_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pinc     = pinc_q;
  assign poff     = poff_q;
  assign resync   = resync_q;
  assign valid_in = valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tone_idx = tone_idx_q;

endmodule

// File: tb/tb_test_sig_sweep_ctrl.sv
// Directed bench for test_sig_sweep_ctrl: hand-computed sweeps, pause, abort, zero-tone and reset cases.
module tb_test_sig_sweep_ctrl;

  localparam int PW = 20;
  localparam int SW = 16;
  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          m_axis_areset;
  logic [PW-1:0] cfg_pinc_start, cfg_pinc_step, cfg_poff;
  logic [SW-1:0] cfg_num_tones;
  logic [DW-1:0] cfg_dwell;
  logic          start, abort, pause;
  logic [PW-1:0] pinc, poff;
  logic          resync, valid_in, busy, done;
  logic [SW-1:0] tone_idx;

  always #5 clk = ~clk;

  test_sig_sweep_ctrl #(
    .PHASE_W(PW), .STEP_W(SW), .DWELL_W(DW), .RESYNC_EACH(1)
  ) dut (
    .m_axis_aclk   (clk),
    .m_axis_areset (m_axis_areset),
    .cfg_pinc_start(cfg_pinc_start),
    .cfg_pinc_step (cfg_pinc_step),
    .cfg_poff      (cfg_poff),
    .cfg_num_tones (cfg_num_tones),
    .cfg_dwell     (cfg_dwell),
    .start         (start),
    .abort         (abort),
    .pause         (pause),
    .pinc          (pinc),
    .poff          (poff),
    .resync        (resync),
    .valid_in      (valid_in),
    .busy          (busy),
    .done          (done),
    .tone_idx      (tone_idx)
  );

  int n_cmp = 0;
  int n_err = 0;

  int n_valid, n_resync, n_busy, first_valid, done_cyc, pinc_bad, poff_bad, dseen;
  int tone_len [8];
  logic [PW-1:0] exp_pinc [8];
  logic [PW-1:0] exp_poff;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input logic [PW-1:0] ps, input logic [PW-1:0] st,
                         input logic [PW-1:0] po, input logic [SW-1:0] nt,
                         input logic [DW-1:0] dw);
    cfg_pinc_start = ps;
    cfg_pinc_step  = st;
    cfg_poff       = po;
    cfg_num_tones  = nt;
    cfg_dwell      = dw;
  endtask

  task automatic scramble_cfg();
    set_cfg(20'hABCDE, 20'h77777, 20'h0F0F0, 16'd9, 24'd1);
  endtask

  // After return we sit one edge past the capture edge (sample index 1).
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Samples once per cycle until done is seen or the budget runs out; index i counts edges since start.
  task automatic observe(input int budget, input int p_from, input int p_len,
                         input int ab_at, input int st_at);
    n_valid = 0; n_resync = 0; n_busy = 0; pinc_bad = 0; poff_bad = 0;
    first_valid = -1; done_cyc = -1;
    foreach (tone_len[k]) tone_len[k] = 0;
    for (int i = 1; i <= budget; i++) begin
      if (valid_in === 1'b1) begin
        n_valid++;
        if (first_valid < 0) first_valid = i;
        tone_len[tone_idx[2:0]]++;
        if (pinc !== exp_pinc[tone_idx[2:0]]) pinc_bad++;
        if (poff !== exp_poff) poff_bad++;
      end
      if (resync === 1'b1) n_resync++;
      if (busy === 1'b1) n_busy++;
      if (done === 1'b1) begin
        done_cyc = i;
        break;
      end
      pause = (i >= p_from) && (i < p_from + p_len);
      abort = (i == ab_at);
      start = (i == st_at);
      tick();
    end
    pause = 1'b0;
    abort = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_idle_after(input string tag);
    tick();
    check({tag, ".done_drop"}, {31'd0, done}, 32'd0);
    check({tag, ".busy_drop"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    m_axis_areset = 1'b1;
    start = 1'b0; abort = 1'b0; pause = 1'b0;
    set_cfg('0, '0, '0, '0, '0);
    tick(); tick();
    m_axis_areset = 1'b0;
    tick();

    // Reset state
    check("rst.pinc",     {12'd0, pinc}, 32'd0);
    check("rst.poff",     {12'd0, poff}, 32'd0);
    check("rst.resync",   {31'd0, resync}, 32'd0);
    check("rst.valid",    {31'd0, valid_in}, 32'd0);
    check("rst.busy",     {31'd0, busy}, 32'd0);
    check("rst.done",     {31'd0, done}, 32'd0);
    check("rst.tone_idx", {16'd0, tone_idx}, 32'd0);

    // Basic 3-tone sweep, cfg scrambled after capture
    set_cfg(20'h01000, 20'h00800, 20'h12345, 16'd3, 24'd4);
    exp_pinc[0] = 20'h01000; exp_pinc[1] = 20'h01800; exp_pinc[2] = 20'h02000;
    exp_poff = 20'h12345;
    do_start();
    check("basic.busy_load",  {31'd0, busy}, 32'd1);
    check("basic.valid_load", {31'd0, valid_in}, 32'd0);
    scramble_cfg();
    observe(40, 0, 0, 0, 0);
    check("basic.first_valid", first_valid, 32'd2);
    check("basic.done_cyc",    done_cyc, 32'd14);
    check("basic.n_valid",     n_valid, 32'd12);
    check("basic.n_resync",    n_resync, 32'd3);
    check("basic.n_busy",      n_busy, 32'd13);
    check("basic.len0",        tone_len[0], 32'd4);
    check("basic.len1",        tone_len[1], 32'd4);
    check("basic.len2",        tone_len[2], 32'd4);
    check("basic.pinc_bad",    pinc_bad, 32'd0);
    check("basic.poff_bad",    poff_bad, 32'd0);
    check("basic.valid_done",  {31'd0, valid_in}, 32'd0);
    check("basic.pinc_keep",   {12'd0, pinc}, 32'h02000);
    check("basic.idx_keep",    {16'd0, tone_idx}, 32'd2);
    check_idle_after("basic");

    // Zero tones
    set_cfg(20'h00400, 20'h00100, 20'h00000, 16'd0, 24'd3);
    do_start();
    observe(10, 0, 0, 0, 0);
    check("zero.done_cyc", done_cyc, 32'd2);
    check("zero.n_valid",  n_valid, 32'd0);
    check("zero.n_busy",   n_busy, 32'd1);
    check_idle_after("zero");

    // Dwell 0 -> one cycle per tone, increment wraps
    set_cfg(20'hFFFFF, 20'h00002, 20'h00007, 16'd2, 24'd0);
    exp_pinc[0] = 20'hFFFFF; exp_pinc[1] = 20'h00001;
    exp_poff = 20'h00007;
    do_start();
    observe(10, 0, 0, 0, 0);
    check("wrap.done_cyc", done_cyc, 32'd4);
    check("wrap.n_valid",  n_valid, 32'd2);
    check("wrap.len0",     tone_len[0], 32'd1);
    check("wrap.len1",     tone_len[1], 32'd1);
    check("wrap.n_resync", n_resync, 32'd2);
    check("wrap.pinc_bad", pinc_bad, 32'd0);
    check_idle_after("wrap");

    // Pause 3 cycles starting on the resync cycle of tone 0
    set_cfg(20'h04000, 20'h01000, 20'h00000, 16'd2, 24'd5);
    exp_pinc[0] = 20'h04000; exp_pinc[1] = 20'h05000;
    exp_poff = 20'h00000;
    do_start();
    observe(40, 2, 3, 0, 0);
    check("pause.done_cyc", done_cyc, 32'd15);
    check("pause.n_valid",  n_valid, 32'd13);
    check("pause.len0",     tone_len[0], 32'd8);
    check("pause.len1",     tone_len[1], 32'd5);
    check("pause.n_resync", n_resync, 32'd2);
    check("pause.pinc_bad", pinc_bad, 32'd0);
    check_idle_after("pause");

    // Abort during tone 1 of 4 (with pause on the same cycle), start mid-sweep ignored
    set_cfg(20'h00100, 20'h00010, 20'h00055, 16'd4, 24'd3);
    exp_pinc[0] = 20'h00100; exp_pinc[1] = 20'h00110;
    exp_pinc[2] = 20'h00120; exp_pinc[3] = 20'h00130;
    exp_poff = 20'h00055;
    do_start();
    observe(40, 6, 1, 6, 4);
    check("abort.done_cyc",   done_cyc, 32'd7);
    check("abort.n_valid",    n_valid, 32'd5);
    check("abort.len1",       tone_len[1], 32'd2);
    check("abort.valid_done", {31'd0, valid_in}, 32'd0);
    check("abort.idx_keep",   {16'd0, tone_idx}, 32'd1);
    check("abort.pinc_keep",  {12'd0, pinc}, 32'h00110);
    check_idle_after("abort");
    tick();
    check("abort.no_queue",   {31'd0, busy}, 32'd0);

    // Start and abort together in IDLE: start wins, full 4-tone sweep runs
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    check("startwin.busy", {31'd0, busy}, 32'd1);
    observe(40, 0, 0, 0, 0);
    check("startwin.done_cyc", done_cyc, 32'd14);
    check("startwin.n_valid",  n_valid, 32'd12);
    check("startwin.pinc_bad", pinc_bad, 32'd0);
    check_idle_after("startwin");

    // Reset mid-DWELL, then a clean sweep
    set_cfg(20'h01000, 20'h00800, 20'h12345, 16'd3, 24'd4);
    exp_pinc[0] = 20'h01000; exp_pinc[1] = 20'h01800; exp_pinc[2] = 20'h02000;
    exp_poff = 20'h12345;
    do_start();
    tick(); tick(); tick();
    m_axis_areset = 1'b1;
    tick();
    m_axis_areset = 1'b0;
    check("mrst.pinc",     {12'd0, pinc}, 32'd0);
    check("mrst.poff",     {12'd0, poff}, 32'd0);
    check("mrst.valid",    {31'd0, valid_in}, 32'd0);
    check("mrst.busy",     {31'd0, busy}, 32'd0);
    check("mrst.done",     {31'd0, done}, 32'd0);
    check("mrst.tone_idx", {16'd0, tone_idx}, 32'd0);
    dseen = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) dseen++;
    end
    check("mrst.quiet", dseen, 32'd0);
    do_start();
    observe(40, 0, 0, 0, 0);
    check("mrst.done_cyc", done_cyc, 32'd14);
    check("mrst.n_valid",  n_valid, 32'd12);
    check("mrst.n_resync", n_resync, 32'd3);
    check("mrst.pinc_bad", pinc_bad, 32'd0);
    check_idle_after("mrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
